random_message_pair: RTL and testbench
======================================

Name:
random_message_pair

Overview:
- Two cooperating message agents in one clocked block.
- Agent A emits a pseudo-random 4-bit message each enabled cycle, scrambled by agent B's last packet.
- Agent B emits a 4×4-bit packet each enabled cycle: nibble 0 echoes A's last message, nibbles 1..3 are pseudo-random.
- Used as a deterministic random-traffic source for bus and link exercising in simulation and on silicon.

Parameters:
- SEED_A, 8'hA5, reset value of agent A's 8-bit LFSR. A value of 0 is replaced by 8'h01.
- SEED_B, 16'hACE1, reset value of agent B's 16-bit LFSR. A value of 0 is replaced by 16'h0001.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance both agents this cycle when 1; hold all state when 0.
- message1_out  output  4  agent A's message (registered).
- message2_out  output  16  agent B's packet (registered): nibble k = bits [4k+3:4k], k = 0..3.
- msg_count  output  8  number of enabled cycles since reset, modulo 256.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset response:
  - lfsr_a <= SEED_A, lfsr_b <= SEED_B (with the zero-seed substitution).
  - message1_out <= 0, message2_out <= 0, msg_count <= 0.
  - Reset has priority over enable.
- LFSR A (8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1):
  - fb = q[7]^q[5]^q[4]^q[3]
  - next = {q[6:0], fb}
- LFSR B (16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1):
  - fb = q[15]^q[13]^q[12]^q[10]
  - next = {q[14:0], fb}
- Enabled cycle (enable=1, reset=0). All right-hand sides are pre-edge register values.
  - lfsr_a <= next(lfsr_a); lfsr_b <= next(lfsr_b).
  - fold = XOR of the four nibbles of message2_out.
  - message1_out <= lfsr_a[3:0] ^ fold.
  - message2_out[3:0] <= message1_out (A-to-B echo, one-cycle latency).
  - message2_out[15:4] <= lfsr_b[15:4].
  - msg_count <= msg_count + 1; wraps from 255 to 0 with no flag.
- Disabled cycle (enable=0, reset=0): every register holds its value.
- Latency:
  - A's message appears one cycle after the enabled edge.
  - A's message is echoed in B's nibble 0 on the following enabled edge.
  - B's packet influences A's message on the following enabled edge.
- LFSRs never reach the all-zero state. Periods are 255 (A) and 65535 (B) enabled cycles.
- No combinational path from any input to any output; all outputs come straight from flops.
- Reset asserted mid-stream restores the exact post-reset sequence; there is no dependence on prior history.

Test Plan:
- Reset with defaults, then hold enable=0 for 3 cycles -> message1_out=4'h0, message2_out=16'h0000, msg_count=0 throughout.
- Reset, then first enabled edge -> message1_out=4'h5, message2_out=16'hACE0, msg_count=1.
- Second enabled edge:
  - lfsr_a=8'h4A, lfsr_b=16'h59C3.
  - message1_out = 4'hA ^ fold(ACE0)=4'h8 -> 4'h2.
  - message2_out=16'h59C5, msg_count=2.
- Enable toggling: after the second enabled edge, deassert enable for 5 cycles -> all outputs frozen at 2 / 59C5 / 2. Re-enable -> the sequence resumes exactly where it stopped.
- Run 256 enabled cycles from reset:
  - msg_count wraps to 0.
  - lfsr_a has returned to 8'h4A (period 255).
  - message2_out[3:0] always equals the message1_out value of the prior enabled cycle.
- Assert reset mid-run, then continue -> outputs reproduce the step-2 and step-3 values bit-exactly. Instantiate with SEED_A=0 -> the sequence matches seed 8'h01.

Source files
------------

// File: rtl/random_message_pair.sv
// Two cooperating pseudo-random message agents: A emits a 4-bit message scrambled by
// B's last packet, B emits a 16-bit packet whose low nibble echoes A's last message.
module random_message_pair #(
   parameter logic [7:0]  SEED_A = 8'hA5,
   parameter logic [15:0] SEED_B = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   output logic [3:0]  message1_out,
   output logic [15:0] message2_out,
   output logic [7:0]  msg_count
);

   // An all-zero seed would lock the LFSR at zero forever, so it is replaced by 1.
   localparam logic [7:0]  SEED_A_EFF = (SEED_A == 8'h00)    ? 8'h01    : SEED_A;
   localparam logic [15:0] SEED_B_EFF = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;

   logic [7:0]  lfsr_a_reg, lfsr_a_next;
   logic [15:0] lfsr_b_reg, lfsr_b_next;
   logic [3:0]  message1_reg, message1_next;
   logic [15:0] message2_reg, message2_next;
   logic [7:0]  count_reg, count_next;

   logic [3:0] fold_chain [0:4];
   logic [3:0] fold;

   assign fold_chain[0] = 4'h0;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fold
         assign fold_chain[gi+1] = fold_chain[gi] ^ message2_reg[4*gi +: 4];
      end
   endgenerate

   assign fold = fold_chain[4];

   // Fibonacci taps: x^8+x^6+x^5+x^4+1 and x^16+x^14+x^13+x^11+1.
   always_comb begin
      lfsr_a_next   = {lfsr_a_reg[6:0],
                       lfsr_a_reg[7] ^ lfsr_a_reg[5] ^ lfsr_a_reg[4] ^ lfsr_a_reg[3]};
      lfsr_b_next   = {lfsr_b_reg[14:0],
                       lfsr_b_reg[15] ^ lfsr_b_reg[13] ^ lfsr_b_reg[12] ^ lfsr_b_reg[10]};
      message1_next = lfsr_a_reg[3:0] ^ fold;
      message2_next = {lfsr_b_reg[15:4], message1_reg};
      count_next    = count_reg + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_a_reg   <= SEED_A_EFF;
         lfsr_b_reg   <= SEED_B_EFF;
         message1_reg <= 4'h0;
         message2_reg <= 16'h0000;
         count_reg    <= 8'h00;
      end else if (enable) begin
         lfsr_a_reg   <= lfsr_a_next;
         lfsr_b_reg   <= lfsr_b_next;
         message1_reg <= message1_next;
         message2_reg <= message2_next;
         count_reg    <= count_next;
      end
   end

   assign message1_out = message1_reg;
   assign message2_out = message2_reg;
   assign msg_count    = count_reg;

endmodule

// File: tb/tb_random_message_pair.sv
// Scoreboard bench for random_message_pair: default-seed instance plus a zero-seed instance
// that must behave like seed 8'h01.
module tb_random_message_pair;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [3:0]  m1, z1;
   logic [15:0] m2, z2;
   logic [7:0]  mc, zc;

   always #5 clk = ~clk;

   random_message_pair dut (
      .clock(clk), .reset(reset), .enable(enable),
      .message1_out(m1), .message2_out(m2), .msg_count(mc)
   );

   random_message_pair #(.SEED_A(8'h00)) dut_z (
      .clock(clk), .reset(reset), .enable(enable),
      .message1_out(z1), .message2_out(z2), .msg_count(zc)
   );

   typedef struct {
      int          id;
      logic [3:0]  m1;
      logic [15:0] m2;
      logic [7:0]  mc;
      logic [3:0]  z1;
      logic [15:0] z2;
      logic [7:0]  zc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   step_id = 0;

   // Reference model: index 0 = seed A5, index 1 = seed 01 (expected for the zero-seed instance).
   logic [7:0]  ma [2];
   logic [15:0] mb [2];
   logic [3:0]  om1 [2];
   logic [15:0] om2 [2];
   logic [7:0]  omc [2];

   task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, exp);
      end
   endtask

   task automatic model_step(input bit rst, input bit en);
      logic [3:0] f;
      logic [3:0] nm1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            ma[k]  = (k == 0) ? 8'hA5 : 8'h01;
            mb[k]  = 16'hACE1;
            om1[k] = 4'h0;
            om2[k] = 16'h0000;
            omc[k] = 8'h00;
         end else if (en) begin
            f      = om2[k][3:0] ^ om2[k][7:4] ^ om2[k][11:8] ^ om2[k][15:12];
            nm1    = ma[k][3:0] ^ f;
            om2[k] = {mb[k][15:4], om1[k]};
            om1[k] = nm1;
            ma[k]  = {ma[k][6:0], ma[k][7] ^ ma[k][5] ^ ma[k][4] ^ ma[k][3]};
            mb[k]  = {mb[k][14:0], mb[k][15] ^ mb[k][13] ^ mb[k][12] ^ mb[k][10]};
            omc[k] = omc[k] + 8'd1;
         end
      end
   endtask

   // Drive one cycle; hand=1 uses the given hand-computed values for the main instance.
   task automatic step(input bit rst, input bit en, input bit hand,
                       input logic [3:0] h1, input logic [15:0] h2, input logic [7:0] hc);
      exp_t e;
      @(negedge clk);
      reset  = rst;
      enable = en;
      model_step(rst, en);
      step_id++;
      e.id = step_id;
      e.m1 = hand ? h1 : om1[0];
      e.m2 = hand ? h2 : om2[0];
      e.mc = hand ? hc : omc[0];
      e.z1 = om1[1];
      e.z2 = om2[1];
      e.zc = omc[1];
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("message1", e.id, {12'h0, m1}, {12'h0, e.m1});
         chk("message2", e.id, m2, e.m2);
         chk("msg_count", e.id, {8'h0, mc}, {8'h0, e.mc});
         chk("z_message1", e.id, {12'h0, z1}, {12'h0, e.z1});
         chk("z_message2", e.id, z2, e.z2);
         chk("z_msg_count", e.id, {8'h0, zc}, {8'h0, e.zc});
      end
   end

   initial begin
      int budget;
      // Reset, then idle: everything stays zero.
      step(1, 0, 1, 4'h0, 16'h0000, 8'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 4'h0, 16'h0000, 8'd0);
      // First two enabled edges.
      step(0, 1, 1, 4'h5, 16'hACE0, 8'd1);
      step(0, 1, 1, 4'h2, 16'h59C5, 8'd2);
      // Frozen while disabled, then resume.
      for (int i = 0; i < 5; i++) step(0, 0, 1, 4'h2, 16'h59C5, 8'd2);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 4'h0, 16'h0, 8'd0);
      // Mid-run reset (with enable high, reset wins) reproduces the opening sequence.
      step(1, 1, 1, 4'h0, 16'h0000, 8'd0);
      step(0, 1, 1, 4'h5, 16'hACE0, 8'd1);
      step(0, 1, 1, 4'h2, 16'h59C5, 8'd2);
      // 256 enabled cycles from reset: counter wraps, LFSR A is one step past its seed.
      step(1, 0, 1, 4'h0, 16'h0000, 8'd0);
      for (int i = 0; i < 255; i++) step(0, 1, 0, 4'h0, 16'h0, 8'd0);
      step(0, 1, 0, 4'h0, 16'h0, 8'd0);
      @(posedge clk);
      #2;
      chk("wrap_count", step_id, {8'h0, mc}, 16'h0000);
      chk("lfsr_a_period", step_id, {8'h0, dut.lfsr_a_reg}, 16'h004A);
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         #2;
         budget--;
      end
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
